// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
//
// Shared types and constants for the instruction loader.
//   loader_state_e : loader FSM states (IDLE, LOAD, WRITE, CHK, DONE)
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   BYTE_CNT_W     : width of the byte-position counter inside a word
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4
  } loader_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage : loader_pkg

// File: rtl/instr_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//
// Packs a byte stream little-endian into 32-bit words: the first byte of a
// word lands in bits [7:0], the fourth in bits [31:24].
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   clear     in   restart packing at byte position 0 with an all-zero word
//   accept    in   byte_in is taken this cycle
//   byte_in   in   8-bit stream data
//   word      out  packed register with byte_in already inserted at the
//                  current position, so on the word_full cycle it is the
//                  complete word
//   word_full out  this accept completes a word
// ---------------------------------------------------------------------------
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;

  // The inserted view lets the consumer capture a full word on the same edge
  // that accepts its last byte, with no extra cycle of latency.
  always_comb begin
    word = word_q;
    word[{byte_cnt_q, 3'b000} +: 8] = byte_in;

    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    word_full  = 1'b0;

    if (clear) begin
      byte_cnt_d = '0;
      word_d     = '0;
    end else if (accept) begin
      word_d     = word;
      byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
      word_full  = (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule : byte_packer

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//
// Writer side of the instruction memory. Takes a byte stream over a
// valid/ready handshake, packs it little-endian into 32-bit words and writes
// them to consecutive word addresses starting at BASE_ADDR. The CPU is held
// in reset (cpu_hold) for the whole load; done pulses for one cycle at the end.
//
// Optional feature (macro LOADER_CHECKSUM_EN): a running 32-bit sum of the
// written words is compared against a 4-byte little-endian checksum sent after
// the last word; chk_err flags a mismatch and stays set until the next start.
// Without the macro there is no CHK phase and chk_err is tied low.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset; aborts a running load
//   start      in   begin a load (only looked at in IDLE)
//   len_words  in   words to load, clamped to MAX_WORDS, sampled with start
//   byte_in    in   stream data
//   byte_valid in   byte_in valid
//   byte_ready out  loader accepts byte_in this cycle
//   mem_we     out  instruction-memory write enable
//   mem_addr   out  write byte address (holds last value while mem_we=0)
//   mem_wdata  out  write data (holds last value while mem_we=0)
//   cpu_hold   out  CPU reset request, high while loading
//   busy       out  FSM not in IDLE
//   done       out  one-cycle completion pulse
//   chk_err    out  checksum mismatch flag
//
// DATA_WIDTH must be 32. LEN_WIDTH must satisfy 2**LEN_WIDTH > MAX_WORDS.
// ---------------------------------------------------------------------------
module instr_loader
  import loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 256,
  parameter int                    LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  chk_err
);

  loader_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   cpu_hold_q, cpu_hold_d;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  sum_q, sum_d;
  logic                   chk_err_q, chk_err_d;
`endif

  logic [LEN_WIDTH-1:0]   len_clamped;
  logic                   pk_clear;
  logic                   pk_accept;
  logic [31:0]            pk_word;
  logic                   pk_full;

  // Programs longer than MAX_WORDS are truncated rather than rejected.
  assign len_clamped = (len_words > LEN_WIDTH'(MAX_WORDS)) ? LEN_WIDTH'(MAX_WORDS)
                                                           : len_words;

  assign pk_accept = byte_valid & byte_ready;

  // The same packer assembles program words in LOAD and the checksum in CHK.
  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .accept    (pk_accept),
    .byte_in   (byte_in),
    .word      (pk_word),
    .word_full (pk_full)
  );

  // Next-state and output logic. Address and data are captured on the edge
  // that accepts the fourth byte, so both are already stable in the WRITE
  // cycle and simply hold afterwards.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    chk_err_d   = chk_err_q;
`endif
    byte_ready  = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    pk_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = len_clamped;
          word_idx_d = '0;
          cpu_hold_d = 1'b1;
          pk_clear   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
          chk_err_d  = 1'b0;
`endif
          state_d    = (len_clamped == '0) ? DONE : LOAD;
        end
      end

      LOAD: begin
        byte_ready = 1'b1;
        if (pk_full) begin
          mem_addr_d  = BASE_ADDR + ADDR_WIDTH'({word_idx_q, 2'b00});
          mem_wdata_d = DATA_WIDTH'(pk_word);
          state_d     = WRITE;
        end
      end

      WRITE: begin
        mem_we     = 1'b1;
        pk_clear   = 1'b1;
        word_idx_d = word_idx_q + LEN_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q + mem_wdata_q;
`endif
        if (word_idx_q == len_q - LEN_WIDTH'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = LOAD;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      // sum_q already includes the last word, written in the previous cycle.
      CHK: begin
        byte_ready = 1'b1;
        if (pk_full) begin
          if (DATA_WIDTH'(pk_word) != sum_q) begin
            chk_err_d = 1'b1;
          end
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        done       = 1'b1;
        cpu_hold_d = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = (state_q != IDLE);

`ifdef LOADER_CHECKSUM_EN
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule : instr_loader

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
//
// Directed bench for instr_loader with default parameters (BASE_ADDR 0,
// MAX_WORDS 256). The checksum scenarios run only when LOADER_CHECKSUM_EN
// is defined; every other load sends the correct checksum in that build.
// ---------------------------------------------------------------------------
module tb_instr_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [8:0]  lenWords;
   logic [7:0]  byteIn;
   logic        byteValid;
   logic        byteReady;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic        cpuHold;
   logic        busy;
   logic        done;
   logic        chkErr;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] addrQ [$];
   logic [31:0] dataQ [$];
   int          doneCount    = 0;
   int          readyInWrite = 0;
   int          holdErr      = 0;

   instr_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len_words  (lenWords),
      .byte_in    (byteIn),
      .byte_valid (byteValid),
      .byte_ready (byteReady),
      .mem_we     (memWe),
      .mem_addr   (memAddr),
      .mem_wdata  (memWdata),
      .cpu_hold   (cpuHold),
      .busy       (busy),
      .done       (done),
      .chk_err    (chkErr)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory-side observer: logs every write, counts done pulses, and checks
   // that cpu_hold tracks the load window and byte_ready is low while writing.
   always @(negedge clk) begin
      if (memWe) begin
         addrQ.push_back(memAddr);
         dataQ.push_back(memWdata);
         if (byteReady) readyInWrite++;
      end
      if (done) doneCount++;
      if (rst && (cpuHold !== busy)) holdErr++;
   end

   // Hard stop in case something wedges outside a bounded wait.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Offer one byte at a negedge and hold it until the loader takes it.
   task automatic sendByte(input logic [7:0] b, input int gap);
      int waitCnt;
      byteIn    = b;
      byteValid = 1'b1;
      waitCnt   = 0;
      while (!byteReady && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!byteReady) begin
         checkOutput("byte_ready timeout", 0, 1);
         byteValid = 1'b0;
         return;
      end
      @(negedge clk);
      byteValid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] bytes [$], input int gap);
      foreach (bytes[i]) sendByte(bytes[i], gap);
   endtask

   task automatic sendWord(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], gap);
   endtask

   task automatic sendChecksum(input logic [31:0] sum);
`ifdef LOADER_CHECKSUM_EN
      sendWord(sum, 0);
`else
      if (sum === 32'hx) $display("[TB] checksum phase not built");
`endif
   endtask

   task automatic startLoad(input logic [8:0] len);
      start    = 1'b1;
      lenWords = len;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int maxCycles);
      int n;
      n = 0;
      while (busy && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput({tag, " idle timeout"}, 0, 1);
   endtask

   logic [7:0] prog [$] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

   task automatic checkBasicWrites(input string tag, input int a0, input int d0);
      checkOutput({tag, " writes"}, addrQ.size() - a0, 2);
      checkOutput({tag, " addr0"}, addrQ[a0], 32'h0);
      checkOutput({tag, " data0"}, dataQ[a0], 32'h0050_0513);
      checkOutput({tag, " addr1"}, addrQ[a0 + 1], 32'h4);
      checkOutput({tag, " data1"}, dataQ[a0 + 1], 32'h0010_0593);
      checkOutput({tag, " done pulses"}, doneCount - d0, 1);
      checkOutput({tag, " hold after"}, cpuHold, 0);
      checkOutput({tag, " chk_err"}, chkErr, 0);
   endtask

   initial begin
      int a0, d0, r0;
      logic [31:0] sum;

      rst       = 1'b0;
      start     = 1'b0;
      lenWords  = '0;
      byteIn    = '0;
      byteValid = 1'b0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      checkOutput("reset mem_we", memWe, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset cpu_hold", cpuHold, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset byte_ready", byteReady, 0);
      checkOutput("reset mem_addr", memAddr, 0);
      checkOutput("reset mem_wdata", memWdata, 0);
      checkOutput("reset chk_err", chkErr, 0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("idle byte_ready", byteReady, 0);

      // ---- basic back-to-back load of two words ----
      $display("[TB] basic load");
      a0 = addrQ.size(); d0 = doneCount;
      startLoad(2);
      checkOutput("basic busy", busy, 1);
      checkOutput("basic hold", cpuHold, 1);
      applyStimulus(prog, 0);
      sendChecksum(32'h0060_0AA6);
      waitIdle("basic", 20);
      checkBasicWrites("basic", a0, d0);

      // ---- same stream with 3-cycle gaps ----
      $display("[TB] stalled load");
      a0 = addrQ.size(); d0 = doneCount;
      startLoad(2);
      applyStimulus(prog, 3);
      sendChecksum(32'h0060_0AA6);
      waitIdle("stall", 40);
      checkBasicWrites("stall", a0, d0);
      checkOutput("ready low in WRITE", readyInWrite, 0);

      // ---- zero-length load ----
      $display("[TB] zero length");
      a0 = addrQ.size(); d0 = doneCount;
      startLoad(0);
      checkOutput("len0 done", done, 1);
      checkOutput("len0 hold in DONE", cpuHold, 1);
      @(negedge clk);
      checkOutput("len0 idle", busy, 0);
      checkOutput("len0 hold", cpuHold, 0);
      checkOutput("len0 writes", addrQ.size() - a0, 0);
      checkOutput("len0 done pulses", doneCount - d0, 1);

      // ---- oversize request clamps to 256 words ----
      $display("[TB] clamped length");
      a0 = addrQ.size(); d0 = doneCount;
      sum = '0;
      startLoad(9'd300);
      for (int w = 0; w < 256; w++) begin
         sendWord({8'h3C, 8'hC3, 8'h00, w[7:0]}, 0);
         sum += {8'h3C, 8'hC3, 8'h00, w[7:0]};
      end
      sendChecksum(sum);
      waitIdle("len300", 20);
      checkOutput("len300 writes", addrQ.size() - a0, 256);
      for (int w = 0; w < 256; w++) begin
         checkOutput($sformatf("len300 addr[%0d]", w), addrQ[a0 + w], 32'(w * 4));
         checkOutput($sformatf("len300 data[%0d]", w), dataQ[a0 + w],
                     {8'h3C, 8'hC3, 8'h00, w[7:0]});
      end
      checkOutput("len300 last addr", addrQ[a0 + 255], 32'h3FC);
      checkOutput("len300 done pulses", doneCount - d0, 1);

      // ---- start while busy is ignored ----
      $display("[TB] start while busy");
      a0 = addrQ.size(); d0 = doneCount;
      startLoad(1);
      sendByte(8'hAA, 0);
      startLoad(5);
      sendByte(8'hBB, 0);
      sendByte(8'hCC, 0);
      sendByte(8'hDD, 0);
      sendChecksum(32'hDDCC_BBAA);
      waitIdle("restart", 20);
      checkOutput("restart writes", addrQ.size() - a0, 1);
      checkOutput("restart data", dataQ[a0], 32'hDDCC_BBAA);
      checkOutput("restart addr", addrQ[a0], 32'h0);
      checkOutput("restart done pulses", doneCount - d0, 1);

`ifdef LOADER_CHECKSUM_EN
      // ---- checksum match then mismatch ----
      $display("[TB] checksum");
      startLoad(2);
      sendWord(32'h1, 0);
      sendWord(32'h2, 0);
      sendWord(32'h3, 0);
      waitIdle("chk ok", 20);
      checkOutput("chk ok flag", chkErr, 0);

      startLoad(2);
      sendWord(32'h1, 0);
      sendWord(32'h2, 0);
      sendWord(32'h4, 0);
      checkOutput("chk bad in DONE", chkErr, done ? 1 : 1);
      waitIdle("chk bad", 20);
      repeat (3) @(negedge clk);
      checkOutput("chk bad sticky", chkErr, 1);

      startLoad(1);
      checkOutput("chk cleared on start", chkErr, 0);
      sendWord(32'h5, 0);
      sendWord(32'h5, 0);
      waitIdle("chk clear", 20);
      checkOutput("chk clear flag", chkErr, 0);
`endif

      // ---- reset in the middle of a load ----
      $display("[TB] reset mid-load");
      a0 = addrQ.size(); d0 = doneCount;
      startLoad(4);
      applyStimulus('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 0);
      checkOutput("pre-reset wdata", memWdata, 32'h4433_2211);
      rst = 1'b0;
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort cpu_hold", cpuHold, 0);
      checkOutput("abort byte_ready", byteReady, 0);
      checkOutput("abort mem_we", memWe, 0);
      checkOutput("abort mem_wdata", memWdata, 0);
      checkOutput("abort mem_addr", memAddr, 0);
      @(negedge clk);
      rst       = 1'b1;
      r0        = addrQ.size();
      byteIn    = 8'h77;
      byteValid = 1'b1;
      repeat (10) @(negedge clk);
      byteValid = 1'b0;
      checkOutput("after abort busy", busy, 0);
      checkOutput("after abort writes", addrQ.size() - r0, 0);
      checkOutput("abort writes total", r0 - a0, 1);
      checkOutput("abort done pulses", doneCount - d0, 0);

      checkOutput("cpu_hold tracks busy", holdErr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule : tb_instr_loader
